// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes, FSM states and
// result beat indices.
package seq_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_OUT0,
    S_OUT1
  } state_t;

  localparam logic BEAT0 = 1'b0;
  localparam logic BEAT1 = 1'b1;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the multi-cycle ops: synchronous clear, count enable,
// and a terminal flag when the count equals LAST.
module iter_counter #(
  parameter int CNT_W = 3,
  parameter int LAST  = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign term = (count_reg == CNT_W'(LAST));

endmodule

// File: rtl/seq_alu_w.sv
// Multi-cycle integer ALU (add/sub/Booth multiply/restoring divide) with
// operands and results streamed over a shared valid/ready beat bus.
module seq_alu_w
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic [1:0]       op,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             ovf,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_reg, state_next;
  op_t              op_reg;
  logic [WIDTH-1:0] a_reg, q_reg, m_reg;
  logic             qm1_reg, ovf_reg, dbz_reg, out_valid_reg;

  logic             out_fire, iterative, y_zero_div;
  logic             cnt_clr, cnt_en, cnt_term;
  logic [WIDTH:0]   add_a, add_b, add_sum;
  logic             add_sub;
  logic [WIDTH-1:0] div_a, div_q, beat_data;
  logic             beat;

  assign out_fire   = out_valid_reg & out_ready;
  assign iterative  = (op_reg == OP_MUL) || (op_reg == OP_DIV);
  assign y_zero_div = (op_reg == OP_DIV) && (in_data == '0);
  assign cnt_clr    = (state_reg == S_LOAD_Y) && in_valid;
  assign cnt_en     = (state_reg == S_EXEC) && iterative;

  iter_counter #(
    .CNT_W (CNT_W),
    .LAST  (WIDTH - 1)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term)
  );

  // One extra bit so Booth's A-M with M = most-negative and the divider's
  // shifted partial remainder never wrap.
  always_comb begin
    add_a   = {a_reg[WIDTH-1], a_reg};
    add_b   = '0;
    add_sub = 1'b0;
    case (op_reg)
      OP_ADD, OP_SUB: begin
        add_a   = {q_reg[WIDTH-1], q_reg};
        add_b   = {m_reg[WIDTH-1], m_reg};
        add_sub = (op_reg == OP_SUB);
      end
      OP_MUL: begin
        case ({q_reg[0], qm1_reg})
          2'b01:   add_b = {m_reg[WIDTH-1], m_reg};
          2'b10: begin
            add_b   = {m_reg[WIDTH-1], m_reg};
            add_sub = 1'b1;
          end
          default: add_b = '0;
        endcase
      end
      default: begin
        add_a   = {a_reg, q_reg[WIDTH-1]};
        add_b   = {1'b0, m_reg};
        add_sub = 1'b1;
      end
    endcase
    add_sum = add_a + (add_sub ? ~add_b : add_b) + {{WIDTH{1'b0}}, add_sub};
  end

  assign div_q = {q_reg[WIDTH-2:0], ~add_sum[WIDTH]};
  assign div_a = add_sum[WIDTH] ? add_a[WIDTH-1:0] : add_sum[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (in_valid) state_next = S_LOAD_Y;
      S_LOAD_Y: if (in_valid) state_next = y_zero_div ? S_OUT0 : S_EXEC;
      S_EXEC:   if (!iterative || cnt_term) state_next = S_OUT0;
      S_OUT0:   if (out_fire) state_next = iterative ? S_OUT1 : S_IDLE;
      S_OUT1:   if (out_fire) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_reg        <= OP_ADD;
      a_reg         <= '0;
      q_reg         <= '0;
      m_reg         <= '0;
      qm1_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      dbz_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            q_reg   <= in_data;
            op_reg  <= op_t'(op);
            a_reg   <= '0;
            qm1_reg <= 1'b0;
            ovf_reg <= 1'b0;
            dbz_reg <= 1'b0;
          end
        end
        S_LOAD_Y: begin
          if (in_valid) begin
            m_reg <= in_data;
            if (y_zero_div) dbz_reg <= 1'b1;
          end
        end
        S_EXEC: begin
          case (op_reg)
            OP_ADD, OP_SUB: begin
              a_reg   <= add_sum[WIDTH-1:0];
              ovf_reg <= add_sum[WIDTH] ^ add_sum[WIDTH-1];
            end
            OP_MUL: begin
              a_reg   <= add_sum[WIDTH:1];
              q_reg   <= {add_sum[0], q_reg[WIDTH-1:1]};
              qm1_reg <= q_reg[0];
              if (cnt_term) ovf_reg <= (add_sum[WIDTH:1] != {WIDTH{add_sum[0]}});
            end
            default: begin
              a_reg <= div_a;
              q_reg <= div_q;
            end
          endcase
        end
        default: ;
      endcase

      // out_valid trails the entry into OUT0 by a cycle; beat 1 follows beat 0 directly.
      case (state_reg)
        S_OUT0:  out_valid_reg <= !out_fire || iterative;
        S_OUT1:  out_valid_reg <= !out_fire;
        default: out_valid_reg <= 1'b0;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_reg == S_IDLE) || (state_reg == S_LOAD_Y);
    busy      = (state_reg != S_IDLE);
    beat      = (state_reg == S_OUT1) ? BEAT1 : BEAT0;
    beat_data = a_reg;
    case (op_reg)
      OP_MUL: beat_data = (beat == BEAT0) ? a_reg : q_reg;
      OP_DIV: begin
        if (beat == BEAT0) beat_data = dbz_reg ? '1 : q_reg;
        else               beat_data = dbz_reg ? q_reg : a_reg;
      end
      default: beat_data = a_reg;
    endcase
    out_data = out_valid_reg ? beat_data : '0;
    out_last = out_valid_reg && ((beat == BEAT1) || !iterative);
  end

  assign out_valid = out_valid_reg;
  assign ovf       = ovf_reg;
  assign dbz       = dbz_reg;

endmodule

// File: tb/tb_seq_alu_w.sv
// Bench for seq_alu_w (WIDTH=8): directed vector table, reset-abort sequence
// and randomized transactions checked against an arithmetic reference model.
module tb_seq_alu_w;

  localparam int W    = 8;
  localparam int SMAX = 2 ** (W - 1) - 1;
  localparam int SMIN = -(2 ** (W - 1));

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         in_ready, busy;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last, ovf, dbz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           stall;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    int           nb;
    logic         eovf;
    logic         edbz;
    int           lat;
  } vec_t;

  vec_t tbl[10];

  seq_alu_w #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .op        (op),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic vec_t model(input logic [1:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input int stall);
    vec_t r;
    int sx, sy, p;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r.op = o; r.x = x; r.y = y; r.stall = stall;
    r.e0 = '0; r.e1 = '0; r.eovf = 1'b0; r.edbz = 1'b0; r.nb = 2; r.lat = W + 1;
    case (o)
      2'd0, 2'd1: begin
        p = (o == 2'd0) ? sx + sy : sx - sy;
        r.e0 = p[W-1:0];
        r.eovf = (p > SMAX) || (p < SMIN);
        r.nb = 1;
        r.lat = 2;
      end
      2'd2: begin
        p = sx * sy;
        r.e0 = p[2*W-1:W];
        r.e1 = p[W-1:0];
        r.eovf = (p > SMAX) || (p < SMIN);
      end
      default: begin
        if (y == '0) begin
          r.e0 = '1; r.e1 = x; r.edbz = 1'b1; r.lat = 1;
        end else begin
          r.e0 = x / y; r.e1 = x % y;
        end
      end
    endcase
    return r;
  endfunction

  task automatic send_beat(input logic [W-1:0] d, input logic [1:0] o);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_data  = d;
    op       = o;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int t_y, n, nb, lat;
    logic [W-1:0] expb, got0, got1;
    logic last_seen, elast;
    got0 = '0; got1 = '0; nb = 0;
    send_beat(v.x, v.op);
    send_beat(v.y, ~v.op);
    t_y = cyc;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - t_y;
    check({tag, ".latency"}, lat, v.lat);
    if (!out_valid) return;
    for (int b = 0; b < 2; b++) begin
      expb  = (b == 0) ? v.e0 : v.e1;
      elast = (b == v.nb - 1);
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".data"}, 32'(out_data), 32'(expb));
      check({tag, ".last"}, 32'(out_last), 32'(elast));
      check({tag, ".flags"}, 32'({ovf, dbz}), 32'({v.eovf, v.edbz}));
      if (b == 0) got0 = out_data; else got1 = out_data;
      for (int s = 0; s < v.stall; s++) begin
        in_valid = (s % 2 == 0);
        in_data  = W'($urandom);
        @(negedge clk);
        check({tag, ".hold"}, 32'({out_valid, out_data, out_last, in_ready, busy}),
              32'({1'b1, expb, elast, 1'b0, 1'b1}));
      end
      in_valid  = 1'b0;
      last_seen = out_last;
      nb++;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      if (last_seen) break;
    end
    check({tag, ".beats"}, nb, v.nb);
    check({tag, ".idle"}, 32'({busy, in_ready, out_valid}), 32'b010);
    $display("txn %-5s op=%0d x=%02h y=%02h beat0=%02h beat1=%02h lat=%0d", tag, v.op,
             v.x, v.y, got0, got1, lat);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] rx, ry;

    //        op     x      y     st  e0     e1     nb ovf   dbz   lat
    tbl[0] = '{2'd0, 8'h7F, 8'h01, 0, 8'h80, 8'h00, 1, 1'b1, 1'b0, 2};
    tbl[1] = '{2'd2, 8'hFD, 8'h05, 0, 8'hFF, 8'hF1, 2, 1'b0, 1'b0, 9};
    tbl[2] = '{2'd2, 8'h80, 8'h80, 0, 8'h40, 8'h00, 2, 1'b1, 1'b0, 9};
    tbl[3] = '{2'd3, 8'hC8, 8'h07, 0, 8'h1C, 8'h04, 2, 1'b0, 1'b0, 9};
    tbl[4] = '{2'd3, 8'h55, 8'h00, 0, 8'hFF, 8'h55, 2, 1'b0, 1'b1, 1};
    tbl[5] = '{2'd2, 8'h19, 8'h0B, 5, 8'h01, 8'h13, 2, 1'b1, 1'b0, 9};
    tbl[6] = '{2'd1, 8'h80, 8'h01, 0, 8'h7F, 8'h00, 1, 1'b1, 1'b0, 2};
    tbl[7] = '{2'd0, 8'hFF, 8'h01, 2, 8'h00, 8'h00, 1, 1'b0, 1'b0, 2};
    tbl[8] = '{2'd3, 8'h07, 8'hC8, 0, 8'h00, 8'h07, 2, 1'b0, 1'b0, 9};
    tbl[9] = '{2'd2, 8'h7F, 8'h7F, 1, 8'h3F, 8'h01, 2, 1'b1, 1'b0, 9};

    repeat (2) @(negedge clk);
    check("reset_state", 32'({in_ready, busy, out_valid, out_last, ovf, dbz, out_data}),
          32'({1'b1, 5'b00000, 8'h00}));
    rst = 1'b1;
    @(negedge clk);
    check("post_reset", 32'({in_ready, busy, out_valid, out_last, ovf, dbz, out_data}),
          32'({1'b1, 5'b00000, 8'h00}));

    for (int i = 0; i < 10; i++) run_txn(tbl[i], "table");

    // Abort a multiply mid-iteration with reset, then run a clean subtract.
    send_beat(8'h55, 2'd2);
    send_beat(8'h33, 2'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_abort", 32'({out_valid, out_data, out_last, busy, ovf, dbz}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release", 32'({in_ready, busy, out_valid}), 32'b100);
    run_txn('{2'd1, 8'h10, 8'h20, 0, 8'hF0, 8'h00, 1, 1'b0, 1'b0, 2}, "after");

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = W'($urandom);
      ry = W'($urandom);
      if (ro == 2'd3 && $urandom_range(0, 3) == 0) ry = '0;
      run_txn(model(ro, rx, ry, int'($urandom_range(0, 2))), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
